// File: rtl/button_event_classifier_if.sv
// Bundles the debounced button level and the classified event outputs.
// master drives btn and observes events; slave is the classifier itself.
interface button_event_classifier_if;
  logic btn;
  logic pressed;
  logic released;
  logic short_press;
  logic long_press;
  logic double_press;
  logic held;

  modport master (
    output btn,
    input  pressed,
    input  released,
    input  short_press,
    input  long_press,
    input  double_press,
    input  held
  );

  modport slave (
    input  btn,
    output pressed,
    output released,
    output short_press,
    output long_press,
    output double_press,
    output held
  );
endinterface

// File: rtl/button_event_classifier.sv
// Turns a clean button level into one-cycle press/release/short/long/double
// event pulses plus a held level, so downstream logic never times the button.
module button_event_classifier #(
  parameter int LONG_TICKS       = 1000,
  parameter int DOUBLE_GAP_TICKS = 300
) (
  input  logic                      clk,
  input  logic                      rst,
  button_event_classifier_if.slave  bus
);

  localparam int MAX_TICKS = (LONG_TICKS > DOUBLE_GAP_TICKS) ? LONG_TICKS : DOUBLE_GAP_TICKS;
  localparam int CW        = $clog2(MAX_TICKS) + 1;

  // Terminal counts: the counter starts at 0 on the entry edge, so the
  // LONG_TICKS-th high sample after the press edge sees LONG_TICKS-1.
  localparam logic [CW-1:0] C_LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] C_GAP_LAST  = CW'(DOUBLE_GAP_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESS1   = 3'd1,
    S_WAIT_GAP = 3'd2,
    S_PRESS2   = 3'd3,
    S_LONG     = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_cnt_inc;

  logic r_pressed,  w_pressed_next;
  logic r_released, w_released_next;
  logic r_short,    w_short_next;
  logic r_long,     w_long_next;
  logic r_double,   w_double_next;

  // Saturating increment: the counter holds at all-ones instead of wrapping.
  assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);

  // State, counter and event pulses all register on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_double   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_pressed  <= w_pressed_next;
      r_released <= w_released_next;
      r_short    <= w_short_next;
      r_long     <= w_long_next;
      r_double   <= w_double_next;
    end
  end

  // Next-state, counter and pulse decode; every state entry clears the counter.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_pressed_next  = 1'b0;
    w_released_next = 1'b0;
    w_short_next    = 1'b0;
    w_long_next     = 1'b0;
    w_double_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.btn) begin
          w_state_next   = S_PRESS1;
          w_cnt_next     = '0;
          w_pressed_next = 1'b1;
        end
      end
      S_PRESS1: begin
        if (!bus.btn) begin
          w_state_next    = S_WAIT_GAP;
          w_cnt_next      = '0;
          w_released_next = 1'b1;
        end else if (r_cnt == C_LONG_LAST) begin
          w_state_next = S_LONG;
          w_cnt_next   = '0;
          w_long_next  = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_LONG: begin
        // A long press only ends; it never feeds the short/double path.
        if (!bus.btn) begin
          w_state_next    = S_IDLE;
          w_cnt_next      = '0;
          w_released_next = 1'b1;
        end
      end
      S_WAIT_GAP: begin
        // A new press wins over gap expiry in the same cycle.
        if (bus.btn) begin
          w_state_next   = S_PRESS2;
          w_cnt_next     = '0;
          w_pressed_next = 1'b1;
          w_double_next  = 1'b1;
        end else if (r_cnt == C_GAP_LAST) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_short_next = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_PRESS2: begin
        if (!bus.btn) begin
          w_state_next    = S_IDLE;
          w_cnt_next      = '0;
          w_released_next = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign bus.pressed      = r_pressed;
  assign bus.released     = r_released;
  assign bus.short_press  = r_short;
  assign bus.long_press   = r_long;
  assign bus.double_press = r_double;
  assign bus.held         = (r_state == S_PRESS1) || (r_state == S_PRESS2) || (r_state == S_LONG);

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed test-plan scenarios followed by random button activity, each cycle
// checked against a timestamp-based model of the classification rules.
module tb_button_event_classifier;

  localparam int L = 8;
  localparam int D = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_event_classifier_if bus();

  button_event_classifier #(
    .LONG_TICKS(L),
    .DOUBLE_GAP_TICKS(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remembers when the current press started, whether it is
  // the second of a pair, and when the last short-press release happened.
  int  t         = 0;
  bit  in_press  = 0;
  bit  is_second = 0;
  bit  long_done = 0;
  int  start_t   = 0;
  bit  pending   = 0;
  int  rel_t     = 0;
  bit  e_pressed, e_released, e_short, e_long, e_double, e_held;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b cycle=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic model_edge(input bit r, input bit b);
    e_pressed = 0; e_released = 0; e_short = 0; e_long = 0; e_double = 0;
    if (r) begin
      in_press = 0; is_second = 0; long_done = 0; pending = 0;
    end else if (in_press) begin
      if (!b) begin
        e_released = 1;
        in_press   = 0;
        if (!is_second && !long_done) begin
          pending = 1;
          rel_t   = t;
        end
      end else if (!is_second && !long_done && (t - start_t) == L) begin
        e_long    = 1;
        long_done = 1;
      end
    end else begin
      if (b) begin
        e_pressed = 1;
        in_press  = 1;
        long_done = 0;
        start_t   = t;
        is_second = pending;
        e_double  = pending;
        pending   = 0;
      end else if (pending && (t - rel_t) == D) begin
        e_short = 1;
        pending = 0;
      end
    end
    e_held = in_press;
  endtask

  task automatic step(input bit r, input bit b);
    rst     = r;
    bus.btn = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    chk("pressed",      bus.pressed,      e_pressed);
    chk("released",     bus.released,     e_released);
    chk("short_press",  bus.short_press,  e_short);
    chk("long_press",   bus.long_press,   e_long);
    chk("double_press", bus.double_press, e_double);
    chk("held",         bus.held,         e_held);
    t++;
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) step(1'b0, b);
  endtask

  initial begin
    bus.btn = 1'b0;

    $display("scenario reset idle");
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);

    $display("scenario short press");
    hold(1'b1, 4); hold(1'b0, 8);

    $display("scenario long press");
    hold(1'b1, 13); hold(1'b0, 8);

    $display("scenario double press on last gap edge");
    hold(1'b1, 3); hold(1'b0, 5); hold(1'b1, 3); hold(1'b0, 8);

    $display("scenario gap expiry then fresh press");
    hold(1'b1, 3); hold(1'b0, 6); hold(1'b1, 2); hold(1'b0, 8);

    $display("scenario toggle every cycle");
    for (int i = 0; i < 10; i++) step(1'b0, (i % 2) == 0);
    hold(1'b0, 8);

    $display("scenario reset during gap");
    hold(1'b1, 2); hold(1'b0, 2);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    hold(1'b0, 8);

    $display("scenario reset with button held");
    hold(1'b1, 3);
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    hold(1'b1, 3); hold(1'b0, 8);

    for (int seg = 0; seg < 150; seg++) begin
      int  len;
      bit  lvl;
      lvl = seg[0];
      len = (($urandom_range(0, 3) == 0) ? $urandom_range(7, 12) : $urandom_range(1, 6));
      $display("random segment %0d level=%0b cycles=%0d", seg, lvl, len);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 99) < 2) step(1'b1, lvl);
        else step(1'b0, lvl);
      end
    end
    hold(1'b0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
